// File: rtl/tile_scheduler_pkg.sv
// Shared types for the tile scheduler slice.
// Index/op widths, op codes and scheduler FSM states.
package tile_scheduler_pkg;

  localparam int TILE_IDX_W = 3;
  localparam int OP_W       = 3;
  localparam int DONE_W     = 2*TILE_IDX_W+1;

  typedef enum logic [OP_W-1:0] {
    OP_MUL  = 3'd0,
    OP_ADD  = 3'd1,
    OP_SUB  = 3'd2,
    OP_MAC  = 3'd3,
    OP_RELU = 3'd4,
    OP_MAX  = 3'd5,
    OP_MIN  = 3'd6,
    OP_CPY  = 3'd7
  } op_e;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    NEXT,
    FINISH
  } sched_state_e;

endpackage

// File: rtl/tile_scheduler_if.sv
// Command and tile_processor bundle of the scheduler.
// master = scheduler side, slave = controller/processor side.
interface tile_scheduler_if;
  import tile_scheduler_pkg::*;

  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [OP_W-1:0]       cmd_op;
  logic [TILE_IDX_W-1:0] cmd_last_i;
  logic [TILE_IDX_W-1:0] cmd_last_j;
  logic                  tp_start;
  logic [TILE_IDX_W-1:0] tp_tile_i;
  logic [TILE_IDX_W-1:0] tp_tile_j;
  logic [OP_W-1:0]       tp_op_code;
  logic                  tp_done;

  modport master (
    input  cmd_valid, cmd_op,
    input  cmd_last_i, cmd_last_j,
    input  tp_done,
    output cmd_ready, tp_start,
    output tp_tile_i, tp_tile_j,
    output tp_op_code
  );

  modport slave (
    output cmd_valid, cmd_op,
    output cmd_last_i, cmd_last_j,
    output tp_done,
    input  cmd_ready, tp_start,
    input  tp_tile_i, tp_tile_j,
    input  tp_op_code
  );

endinterface

// File: rtl/tile_scheduler_index.sv
// Row-major 2-D tile index counter (load, advance, is_last).
// Ports: clk, rst_n, load+ld_last_i/j, advance -> i, j, is_last.
module tile_index_counter
  import tile_scheduler_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [TILE_IDX_W-1:0] ld_last_i,
  input  logic [TILE_IDX_W-1:0] ld_last_j,
  input  logic                  advance,
  output logic [TILE_IDX_W-1:0] i,
  output logic [TILE_IDX_W-1:0] j,
  output logic                  is_last
);

  logic [TILE_IDX_W-1:0] last_i;
  logic [TILE_IDX_W-1:0] last_j;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_i <= '0;
      last_j <= '0;
      i      <= '0;
      j      <= '0;
    end else if (load) begin
      last_i <= ld_last_i;
      last_j <= ld_last_j;
      i      <= '0;
      j      <= '0;
    end else if (advance) begin
      if (j == last_j) begin
        j <= '0;
        i <= i + 1'b1;
      end else begin
        j <= j + 1'b1;
      end
    end
  end

  assign is_last = (i == last_i) && (j == last_j);

endmodule

// File: rtl/tile_scheduler.sv
// Walks a tile grid row-major, starting tile_processor per tile.
// Ports: clk, rst_n, bus (master), abort, busy, sched_done, err_timeout, tiles_done.
module tile_scheduler
  import tile_scheduler_pkg::*;
#(
  parameter int START_HOLD     = 2,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                clk,
  input  logic                rst_n,
  tile_scheduler_if.master    bus,
  input  logic                abort,
  output logic                busy,
  output logic                sched_done,
  output logic                err_timeout,
  output logic [DONE_W-1:0]   tiles_done
);

  localparam int TMR_MAX =
    (TIMEOUT_CYCLES > START_HOLD) ? TIMEOUT_CYCLES : START_HOLD;
  localparam int TMR_W = (TMR_MAX > 2) ? $clog2(TMR_MAX) : 1;
  localparam logic [TMR_W-1:0] TMR_HOLD = TMR_W'(START_HOLD-1);
  localparam logic [TMR_W-1:0] TMR_TO   = TMR_W'(TIMEOUT_CYCLES-1);

  sched_state_e          state, nxt;
  logic [TMR_W-1:0]      tmr;
  logic [OP_W-1:0]       op;
  logic [TILE_IDX_W-1:0] idx_i, idx_j;
  logic                  is_last;
  logic                  load, adv;
  logic                  tmr_clr, tmr_inc;
  logic                  tile_inc, set_to;

  tile_index_counter u_idx (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .ld_last_i (bus.cmd_last_i),
    .ld_last_j (bus.cmd_last_j),
    .advance   (adv),
    .i         (idx_i),
    .j         (idx_j),
    .is_last   (is_last)
  );

  // tmr counts START_HOLD cycles in ISSUE, then WAIT cycles
  always_comb begin
    nxt      = state;
    load     = 1'b0;
    adv      = 1'b0;
    tmr_clr  = 1'b0;
    tmr_inc  = 1'b0;
    tile_inc = 1'b0;
    set_to   = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.cmd_valid) begin
          load    = 1'b1;
          tmr_clr = 1'b1;
          nxt     = ISSUE;
        end
      end
      ISSUE: begin
        if (abort) begin
          nxt = FINISH;
        end else if (tmr == TMR_HOLD) begin
          tmr_clr = 1'b1;
          nxt     = WAIT;
        end else begin
          tmr_inc = 1'b1;
        end
      end
      WAIT: begin
        // done beats both abort and the final timeout cycle
        if (bus.tp_done) begin
          tile_inc = 1'b1;
          nxt = (abort || is_last) ? FINISH : NEXT;
        end else if (abort) begin
          nxt = FINISH;
        end else if (tmr == TMR_TO) begin
          set_to = 1'b1;
          nxt    = FINISH;
        end else begin
          tmr_inc = 1'b1;
        end
      end
      NEXT: begin
        tmr_clr = 1'b1;
        if (abort) begin
          nxt = FINISH;
        end else begin
          adv = 1'b1;
          nxt = ISSUE;
        end
      end
      FINISH: nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      tmr         <= '0;
      op          <= '0;
      err_timeout <= 1'b0;
      tiles_done  <= '0;
    end else begin
      state <= nxt;
      if (tmr_clr)      tmr <= '0;
      else if (tmr_inc) tmr <= tmr + 1'b1;
      if (load) op <= bus.cmd_op;
      if (load)        err_timeout <= 1'b0;
      else if (set_to) err_timeout <= 1'b1;
      if (load)          tiles_done <= '0;
      else if (tile_inc) tiles_done <= tiles_done + 1'b1;
    end
  end

  assign bus.cmd_ready  = (state == IDLE);
  assign bus.tp_start   = (state == ISSUE);
  assign bus.tp_tile_i  = idx_i;
  assign bus.tp_tile_j  = idx_j;
  assign bus.tp_op_code = op;
  assign busy           = (state != IDLE);
  assign sched_done     = (state == FINISH);

endmodule

// File: tb/tb_tile_scheduler.sv
// Directed bench for tile_scheduler with a scripted tile_processor.
// Checks tile order, start hold, timeout, abort and reset.
`timescale 1ns/1ps
module tb_tile_scheduler;
  import tile_scheduler_pkg::*;

  localparam int TO = 80;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic abort = 1'b0;
  logic busy, sched_done, err_timeout;
  logic [DONE_W-1:0] tiles_done;

  int errors = 0;
  int checks = 0;
  int sd_cnt = 0;
  int sd0;
  int starts;

  tile_scheduler_if bus();

  tile_scheduler #(
    .START_HOLD     (2),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .abort       (abort),
    .busy        (busy),
    .sched_done  (sched_done),
    .err_timeout (err_timeout),
    .tiles_done  (tiles_done)
  );

  always #10.582 clk = ~clk;

  always @(posedge clk)
    if (sched_done) sd_cnt++;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d",
             tag, obs, exp);
    end
  endtask

  task automatic send_cmd(input int op,
                          input int li,
                          input int lj);
    int n = 0;
    while (!bus.cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("cmd_ready_wait", bus.cmd_ready, 1);
    bus.cmd_valid  = 1'b1;
    bus.cmd_op     = OP_W'(op);
    bus.cmd_last_i = TILE_IDX_W'(li);
    bus.cmd_last_j = TILE_IDX_W'(lj);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
  endtask

  // returns on the first WAIT cycle when k == 0,
  // else pulses done on WAIT cycle k and steps one more cycle
  task automatic tile(input int ei, input int ej,
                      input int eop, input int k);
    int n = 0;
    int hold = 0;
    while (!bus.tp_start && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("start_seen", bus.tp_start, 1);
    chk("tile_i", bus.tp_tile_i, ei);
    chk("tile_j", bus.tp_tile_j, ej);
    chk("op_code", bus.tp_op_code, eop);
    while (bus.tp_start && hold < 10) begin
      hold++;
      @(negedge clk);
    end
    chk("start_hold", hold, 2);
    if (k > 0) begin
      repeat (k-1) @(negedge clk);
      bus.tp_done = 1'b1;
      @(negedge clk);
      bus.tp_done = 1'b0;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.cmd_valid  = 1'b0;
    bus.cmd_op     = '0;
    bus.cmd_last_i = '0;
    bus.cmd_last_j = '0;
    bus.tp_done    = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk("rst_ready", bus.cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_start", bus.tp_start, 0);
    chk("rst_sdone", sched_done, 0);
    chk("rst_err", err_timeout, 0);
    chk("rst_tiles", tiles_done, 0);

    // 1x1 grid, done on WAIT cycle 70
    sd0 = sd_cnt;
    send_cmd(0, 0, 0);
    chk("t1_busy", busy, 1);
    chk("t1_ready", bus.cmd_ready, 0);
    tile(0, 0, 0, 70);
    chk("t1_sdone", sched_done, 1);
    chk("t1_tiles", tiles_done, 1);
    chk("t1_err", err_timeout, 0);
    @(negedge clk);
    chk("t1_ready_back", bus.cmd_ready, 1);
    chk("t1_sdone_low", sched_done, 0);
    chk("t1_sd_pulses", sd_cnt - sd0, 1);

    // 2x3 grid, op 5, row-major order
    sd0 = sd_cnt;
    send_cmd(5, 1, 2);
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 3; c++)
        tile(r, c, 5, 64);
    chk("t2_sdone", sched_done, 1);
    chk("t2_tiles", tiles_done, 6);
    @(negedge clk);
    chk("t2_idle", busy, 0);
    chk("t2_sd_pulses", sd_cnt - sd0, 1);

    // 2x2 grid, no done: timeout on tile (0,0)
    sd0 = sd_cnt;
    send_cmd(3, 1, 1);
    tile(0, 0, 3, 0);
    repeat (TO-1) @(negedge clk);
    chk("t3_pre_err", err_timeout, 0);
    chk("t3_pre_busy", busy, 1);
    @(negedge clk);
    chk("t3_sdone", sched_done, 1);
    chk("t3_err", err_timeout, 1);
    chk("t3_tiles", tiles_done, 0);
    @(negedge clk);
    chk("t3_err_sticky", err_timeout, 1);
    chk("t3_sd_pulses", sd_cnt - sd0, 1);
    send_cmd(0, 0, 0);
    chk("t3_err_clr", err_timeout, 0);
    tile(0, 0, 0, 1);
    chk("t3b_tiles", tiles_done, 1);
    @(negedge clk);

    // done on the last allowed WAIT cycle wins
    send_cmd(1, 0, 1);
    tile(0, 0, 1, TO);
    chk("t4_err", err_timeout, 0);
    chk("t4_tiles", tiles_done, 1);
    chk("t4_busy", busy, 1);
    tile(0, 1, 1, 5);
    chk("t4_sdone", sched_done, 1);
    chk("t4_tiles2", tiles_done, 2);
    @(negedge clk);

    // 4x4: abort in WAIT of tile (1,2)
    send_cmd(2, 3, 3);
    for (int t = 0; t < 6; t++)
      tile(t / 4, t % 4, 2, 3);
    tile(1, 2, 2, 0);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("t5_sdone", sched_done, 1);
    chk("t5_tiles", tiles_done, 6);
    chk("t5_err", err_timeout, 0);
    starts = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.tp_start) starts++;
    end
    chk("t5_no_start", starts, 0);
    chk("t5_ready", bus.cmd_ready, 1);

    // 4x4: abort together with done
    send_cmd(4, 3, 3);
    for (int t = 0; t < 6; t++)
      tile(t / 4, t % 4, 4, 3);
    tile(1, 2, 4, 0);
    abort = 1'b1;
    bus.tp_done = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    bus.tp_done = 1'b0;
    chk("t5b_sdone", sched_done, 1);
    chk("t5b_tiles", tiles_done, 7);
    @(negedge clk);

    // reset mid-WAIT with cmd_valid held while busy
    send_cmd(2, 1, 1);
    tile(0, 0, 2, 3);
    tile(0, 1, 2, 0);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 3'd6;
    repeat (3) @(negedge clk);
    chk("t6_ready_busy", bus.cmd_ready, 0);
    chk("t6_op_kept", bus.tp_op_code, 2);
    chk("t6_j_kept", bus.tp_tile_j, 1);
    chk("t6_tiles_pre", tiles_done, 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    bus.cmd_valid = 1'b0;
    chk("t6_busy", busy, 0);
    chk("t6_ready", bus.cmd_ready, 1);
    chk("t6_start", bus.tp_start, 0);
    chk("t6_tile_j", bus.tp_tile_j, 0);
    chk("t6_op", bus.tp_op_code, 0);
    chk("t6_tiles", tiles_done, 0);
    chk("t6_sdone", sched_done, 0);
    sd0 = sd_cnt;
    bus.tp_done = 1'b1;
    @(negedge clk);
    bus.tp_done = 1'b0;
    @(negedge clk);
    chk("t6_idle_done_tiles", tiles_done, 0);
    chk("t6_idle_done_busy", busy, 0);
    chk("t6_idle_done_sd", sd_cnt - sd0, 0);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule

// File: doc/tile_scheduler.md
Name: tile_scheduler

Overview:
- Upstream sequencer for tile_processor. Accepts one matrix-operation command, then walks the tile grid in row-major order.
- For each tile it drives tile_i/tile_j/op_code and a start pulse, then waits for done. Per-tile timeout and abort are supported.
- Reports progress, completion and timeout to the top-level NPU controller.

Parameters:
- TILE_IDX_W, 3, width of tile row/column index (grid up to 8x8).
- OP_W, 3, width of op_code.
- START_HOLD, 2, cycles tp_start is held high per tile (tile_processor samples start over two cycles).
- TIMEOUT_CYCLES, 4096, max WAIT cycles per tile before timeout; must be ≥ 2.

Ports:
- clk  in  1  system clock (47.25 MHz).
- rst_n  in  1  reset, synchronous, active-low.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  high only in IDLE.
- cmd_op  in  OP_W  operation code for all tiles of the command.
- cmd_last_i  in  TILE_IDX_W  last tile row index (rows-1).
- cmd_last_j  in  TILE_IDX_W  last tile column index (cols-1).
- abort  in  1  stop current command.
- tp_start  out  1  start to tile_processor.
- tp_tile_i  out  TILE_IDX_W  current tile row.
- tp_tile_j  out  TILE_IDX_W  current tile column.
- tp_op_code  out  OP_W  latched cmd_op.
- tp_done  in  1  tile_processor completion.
- busy  out  1  high in every state except IDLE.
- sched_done  out  1  one-cycle pulse at command end (normal, abort or timeout).
- err_timeout  out  1  sticky; cleared on next command accept.
- tiles_done  out  2*TILE_IDX_W+1  tiles completed in current command; cleared on accept.

Behaviour:
- Reset (rst_n=0 at a clk edge) takes priority over everything, including mid-command. All outputs go to 0 (cmd_ready=1 since state=IDLE). State=IDLE. Internal counters are cleared.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid: latch op, last_i, last_j; set i=j=0; clear tiles_done and err_timeout; go to ISSUE next cycle.
  - tp_done and abort are ignored in IDLE.
- ISSUE:
  - tp_start=1 for exactly START_HOLD cycles; tp_tile_i/j/op_code valid throughout.
  - Then go to WAIT and clear the timeout counter.
  - Latency: accept at edge N → tp_start high for cycles N+1..N+START_HOLD.
- WAIT:
  - tp_start=0. The timeout counter increments each cycle.
  - If tp_done=1: tiles_done++. If i==last_i and j==last_j, go to FINISH. Otherwise go to NEXT.
  - Else, if the counter reaches TIMEOUT_CYCLES-1: set err_timeout=1 and go to FINISH. Remaining tiles are skipped.
  - If tp_done arrives on the final timeout cycle, done wins and no error is flagged.
  - tp_done during ISSUE is ignored (early-done is not legal for tile_processor).
- NEXT (1 cycle):
  - j++. If j==last_j, then j=0 and i++.
  - Go to ISSUE.
  - tp_tile_i/j change only in NEXT and hold stable until the next NEXT or accept.
- FINISH (1 cycle): sched_done=1, then go to IDLE.
- abort=1 in ISSUE, WAIT or NEXT:
  - tp_start drops on the next edge.
  - Go to FINISH; tiles_done keeps its value; err_timeout is unchanged.
  - abort together with tp_done in WAIT: tiles_done still counts the completed tile, then FINISH.
- Grid of 1x1 (last_i=last_j=0) is legal: one ISSUE/WAIT, then FINISH.
- Index widths: counters never exceed the last_* value, so there is no wrap beyond the grid.

Decomposition:
- Package npu_pkg:
  - TILE_IDX_W and OP_W constants.
  - op_e enum (OP_MUL=0, …).
  - sched_state_e enum {IDLE, ISSUE, WAIT, NEXT, FINISH}.
- One natural sub-module: tile_index_counter.
  - 2-D row-major counter with load/clear, advance and is_last outputs.
  - Instantiated once; FSM and timeout counter stay in tile_scheduler.

Test Plan:
- 1x1 grid, op=0, model asserts tp_done 70 cycles after start → tp_start high exactly 2 cycles with i=0, j=0, op=0; one sched_done pulse; tiles_done=1; err_timeout=0; cmd_ready returns to 1.
- last_i=1, last_j=2, op=5, done after 64 cycles each → tile order (0,0),(0,1),(0,2),(1,0),(1,1),(1,2); tp_op_code=5 throughout; tiles_done=6; single sched_done.
- TIMEOUT_CYCLES=16, 2x2 grid, model never asserts done → err_timeout=1 after 16 WAIT cycles on tile (0,0); sched_done pulse; tiles_done=0; next accepted command clears err_timeout.
- TIMEOUT_CYCLES=16, tp_done on exactly the 16th WAIT cycle → tile counted, no err_timeout, scheduler proceeds to tile (0,1).
- 4x4 grid: abort during WAIT of tile (1,2) → sched_done next cycle; tiles_done=6; no further tp_start. Separately, abort coincident with done → tiles_done=7.
- rst_n=0 for one cycle mid-WAIT, plus cmd_valid held while busy, plus tp_done pulsed in IDLE → all outputs 0 and IDLE after reset; no second command accepted while busy; idle tp_done changes nothing.
